// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
// The transmitter and the arbiter both take their defaults from here.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int UART_BAUD_DIV   = 10415;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_SLACK_BITS = 2;

  // Cycles one frame may occupy the transmitter, including tick-phase slack.
  function automatic int uart_hold_cycles(input int baud_div, input int frame_bits,
                                          input int slack_bits);
    return (baud_div + 1) * (frame_bits + slack_bits);
  endfunction

endpackage

// File: rtl/tx_pace_timer.sv
// Loadable down-counter that paces byte issues to the transmitter.
// done is high while the count sits at zero; the count never wraps below zero.
module tx_pace_timer #(
  parameter int COUNT = 47
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int W = (COUNT < 1) ? 1 : $clog2(COUNT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(COUNT);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between two byte requesters.
// Each won byte is a single valid pulse, followed by a full frame of hold-off.
//
// state | meaning
// IDLE  | waiting for any request; arbitration happens here
// ISSUE | one cycle: tx_valid and ack of the winner are high
// HOLD  | transmitter is shifting the frame; requests ignored
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int SLACK_BITS = UART_SLACK_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        ack0,
  output logic        ack1,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam int HOLD_CYCLES = uart_hold_cycles(BAUD_DIV, FRAME_BITS, SLACK_BITS);

  arb_state_t state, state_nx;
  logic       winner, winner_nx;
  logic       last_grant;
  logic       timer_load;
  logic       timer_done;

  tx_pace_timer #(
    .COUNT (HOLD_CYCLES - 1)
  ) u_pace (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      winner <= 1'b0;
    end else begin
      state  <= state_nx;
      winner <= winner_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    winner_nx  = winner;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = ISSUE;
          // On a tie the requester that did not win last time goes first.
          winner_nx = (req0 & req1) ? ~last_grant : req1;
        end
      end
      ISSUE: begin
        state_nx   = HOLD;
        timer_load = 1'b1;
      end
      HOLD: begin
        if (timer_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are flopped from the next-state decode so nothing reaches a pin
  // combinationally from req.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      tx_data    <= 8'h00;
      byte_count <= 16'd0;
      last_grant <= 1'b1;
    end else begin
      tx_valid <= (state_nx == ISSUE);
      ack0     <= (state_nx == ISSUE) && !winner_nx;
      ack1     <= (state_nx == ISSUE) && winner_nx;
      busy     <= (state_nx != IDLE);
      if (state == IDLE && state_nx == ISSUE) begin
        tx_data <= winner_nx ? data1 : data0;
      end
      if (state == ISSUE) begin
        last_grant <= winner;
        byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule
